// File: rtl/sd_wb_byte_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_bridge_pkg
// Brief    : Shared types and lane-walk helpers for sd_wb_byte_bridge.
// Revision : 1.0 - initial release
// ============================================================================
package sd_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int   LANE_W   = 2;
   localparam int   BYTE_W   = 8;
   localparam int   N_LANES  = 4;
   localparam logic DIR_UP   = 1'b0;   // reads: lane 0 first
   localparam logic DIR_DOWN = 1'b1;   // writes: lane 3 first, byte 0 lands last

   typedef struct packed {
      logic              valid;
      logic [LANE_W-1:0] lane;
   } lane_sel_t;

   // Next set lane strictly after 'lane' in the given walk direction.
   function automatic lane_sel_t next_lane(input logic [N_LANES-1:0] mask,
                                           input logic [LANE_W-1:0]  lane,
                                           input logic               dir);
      lane_sel_t r;
      int        j;
      r = '0;
      for (int i = 0; i < N_LANES; i++) begin
         j = (dir == DIR_UP) ? i : (N_LANES - 1 - i);
         if (!r.valid && mask[j] &&
             ((dir == DIR_UP) ? (j > int'(lane)) : (j < int'(lane)))) begin
            r.valid = 1'b1;
            r.lane  = LANE_W'(j);
         end
      end
      return r;
   endfunction

   // First set lane of a fresh access in the given walk direction.
   function automatic lane_sel_t first_lane(input logic [N_LANES-1:0] mask,
                                            input logic               dir);
      lane_sel_t         r;
      logic [LANE_W-1:0] start;
      start = (dir == DIR_UP) ? LANE_W'(0) : LANE_W'(N_LANES - 1);
      if (mask[start]) begin
         r.valid = 1'b1;
         r.lane  = start;
      end else begin
         r = next_lane(mask, start, dir);
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_wb_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sd_wb_byte_bridge
// Brief    : Wishbone B4 classic 32-bit slave that splits each access into
//            byte accesses on the 8-bit register port of sd_controller_wb.
//            Writes walk lanes 3->0 (selected lanes only), reads walk 0->3.
// Options  : SD_WB_BRIDGE_ERR_EN - adds wb_err_o; sel=0 or word address
//            beyond LAST_REG is answered with an error instead of an ack.
// Revision : 1.0 - initial release
// ============================================================================
module sd_wb_byte_bridge
   import sd_bridge_pkg::*;
#(
   parameter logic [6:0] LAST_REG = 7'h44
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [6:0]  wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
`ifdef SD_WB_BRIDGE_ERR_EN
   output logic        wb_err_o,
`endif
   output logic        we,
   output logic [6:0]  addr,
   output logic [7:0]  data_out,
   input  logic [7:0]  data_in
);

   state_t      r_state, w_state_nxt;
   logic [4:0]  r_wadr;
   logic        r_wr;
   logic [3:0]  r_mask;
   logic [31:0] r_wdat;
   logic [1:0]  r_lane, w_lane_nxt;
   logic        w_load;
   logic [3:0]  w_mask_req;
   lane_sel_t   w_pick;
   logic        w_we_nxt;
   logic [6:0]  w_addr_nxt;
   logic [7:0]  w_dout_nxt;
   logic        w_ack_nxt;
   logic        w_req;
   logic        w_unused;

   assign w_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign w_mask_req = wb_we_i ? wb_sel_i : 4'hF;
   // Byte offset bits are don't-care: lanes are generated internally.
   assign w_unused   = ^{wb_adr_i[1:0], LAST_REG};

`ifdef SD_WB_BRIDGE_ERR_EN
   logic w_bad;
   logic w_err_nxt;
   assign w_bad = (wb_sel_i == 4'h0) || (wb_adr_i[6:2] > LAST_REG[6:2]);
`endif

   // Next-state and next-output decode; all port outputs are registered.
   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane;
      w_load      = 1'b0;
      w_pick      = '0;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = addr;
      w_dout_nxt  = data_out;
      w_ack_nxt   = 1'b0;
`ifdef SD_WB_BRIDGE_ERR_EN
      w_err_nxt   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_load = 1'b1;
               w_pick = first_lane(w_mask_req, wb_we_i ? DIR_DOWN : DIR_UP);
`ifdef SD_WB_BRIDGE_ERR_EN
               if (w_bad) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ACK;
               end else
`endif
               if (w_pick.valid) begin
                  w_state_nxt = XFER;
                  w_lane_nxt  = w_pick.lane;
                  w_we_nxt    = wb_we_i;
                  w_addr_nxt  = {wb_adr_i[6:2], w_pick.lane};
                  if (wb_we_i) w_dout_nxt = wb_dat_i[{w_pick.lane, 3'b000} +: BYTE_W];
               end else begin
                  // Empty write mask: nothing to issue, acknowledge right away.
                  w_state_nxt = ACK;
                  w_ack_nxt   = 1'b1;
               end
            end
         end
         XFER: begin
            w_pick = next_lane(r_mask, r_lane, r_wr ? DIR_DOWN : DIR_UP);
            if (w_pick.valid) begin
               w_lane_nxt = w_pick.lane;
               w_we_nxt   = r_wr;
               w_addr_nxt = {r_wadr, w_pick.lane};
               if (r_wr) w_dout_nxt = r_wdat[{w_pick.lane, 3'b000} +: BYTE_W];
            end else begin
               // A master that abandoned the cycle gets no ack.
               w_state_nxt = ACK;
               w_ack_nxt   = wb_cyc_i;
            end
         end
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, request latch and registered register-port/bus outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_lane   <= '0;
         r_mask   <= '0;
         r_wadr   <= '0;
         r_wdat   <= '0;
         r_wr     <= 1'b0;
         we       <= 1'b0;
         addr     <= '0;
         data_out <= '0;
         wb_ack_o <= 1'b0;
`ifdef SD_WB_BRIDGE_ERR_EN
         wb_err_o <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_lane   <= w_lane_nxt;
         we       <= w_we_nxt;
         addr     <= w_addr_nxt;
         data_out <= w_dout_nxt;
         wb_ack_o <= w_ack_nxt;
`ifdef SD_WB_BRIDGE_ERR_EN
         wb_err_o <= w_err_nxt;
`endif
         if (w_load) begin
            r_wadr <= wb_adr_i[6:2];
            r_wr   <= wb_we_i;
            r_mask <= w_mask_req;
            r_wdat <= wb_dat_i;
         end
      end
   end

   // Read gather: each read cycle captures the byte addressed during it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_dat_o <= '0;
      end else if ((r_state == XFER) && !r_wr) begin
         wb_dat_o[{r_lane, 3'b000} +: BYTE_W] <= data_in;
      end
   end

endmodule
`default_nettype wire

// File: doc/sd_wb_byte_bridge.md
# sd_wb_byte_bridge

Wishbone B4 classic 32-bit slave that feeds the 8-bit register port of `sd_controller_wb`. It splits each 32-bit access into byte-wide accesses on that port, then returns a single ack. Writes issue byte lanes most-significant first so that byte 0 lands last; the byte-0 write to `argument` fires `cmd_start`, and the byte-0 write to `cmd_isr` or `data_isr` fires the interrupt clear. Reads gather all four lanes into `wb_dat_o`.

## Interface
Parameters:
- `LAST_REG`, default 7'h44: highest valid word address, byte offset, word aligned.

Ports:
- `clk` input 1: system clock, the same clock as the register file.
- `rst` input 1: **synchronous, active-low** reset.
- `wb_cyc_i` input 1: bus cycle.
- `wb_stb_i` input 1: strobe.
- `wb_we_i` input 1: write enable.
- `wb_adr_i` input 7: byte address; `[1:0]` is ignored.
- `wb_sel_i` input 4: byte lane enables.
- `wb_dat_i` input 32: write data.
- `wb_dat_o` output 32: read data; valid while `wb_ack_o` is high.
- `wb_ack_o` output 1: one-cycle acknowledge.
- `wb_err_o` output 1: error; present only with `SD_WB_BRIDGE_ERR_EN`.
- `we` output 1: byte write strobe to the register file.
- `addr` output 7: byte address to the register file.
- `data_out` output 8: write byte to the register file.
- `data_in` input 8: combinational read byte from the register file.

## Operation
- Reset values: `we`=0, `addr`=0, `data_out`=0, `wb_dat_o`=0, `wb_ack_o`=0, `wb_err_o`=0. State is IDLE.
- IDLE state:
  - On `wb_cyc_i & wb_stb_i & !wb_ack_o`, latch address, sel, data and we.
  - Set the lane mask: the sel value for a write, 4'b1111 for a read.
  - Go to XFER.
- XFER state:
  - One cycle per set bit of the lane mask.
  - Write lane order is 3→0; unselected lanes are skipped and cost no cycle.
  - Read lane order is 0→3.
  - Outputs for each cycle: `addr`={adr[6:2], lane}. On a write, `we`=1 and `data_out`=wb_dat_i[8*lane+:8]. On a read, `we`=0 and `wb_dat_o[8*lane+:8]` captures `data_in` at the end of the cycle.
  - After the last lane, go to ACK.
- ACK state:
  - `wb_ack_o`=1 for exactly one cycle, but only if `wb_cyc_i` is still high.
  - Go to IDLE.
- `wb_cyc_i` dropped during XFER: the remaining lanes are still issued, so a register is never left half-written. No ack is given.
- Reset during XFER: `we` is low on the next cycle, the FSM returns to IDLE, and the partial write is lost.
- A write with `wb_sel_i`=0 and no ERR_EN: there are zero XFER cycles and the FSM goes straight to ACK.
- Accesses are never pipelined. A new request is sampled only in IDLE.

## Timing
- Let cycle 0 be the cycle in which the request is sampled in IDLE.
- XFER occupies cycles 1..N, where N = popcount of the lane mask. ACK is at cycle N+1.
- A full-word write or any read acks at cycle 5. A single-byte write acks at cycle 2.
- `we`, `addr` and `data_out` are registered. They change only on clock edges, with no glitch between lanes.
- Read data path: registered `addr` → combinational `data_in` → capture register. This is a single-cycle path.
- Back-to-back requests have a minimum spacing of N+2 cycles.

## Configuration
- Macro: `SD_WB_BRIDGE_ERR_EN`.
- Defined:
  - The `wb_err_o` port exists.
  - A request with `wb_sel_i`=0, or with word address > `LAST_REG`, skips XFER.
  - `wb_err_o`=1 at cycle 1, `wb_ack_o` stays 0, and `we` never asserts.
- Undefined:
  - There is no `wb_err_o` port.
  - Out-of-range addresses are forwarded unchanged.
  - sel=0 acks per the Operation rules.

## Structure
- Package `sd_bridge_pkg` contains:
  - state enum `{IDLE, XFER, ACK}`;
  - lane-width constants;
  - function `next_lane(mask, lane, dir)` that returns the next set lane for either order.
- No sub-module. Everything is one FSM, one 2-bit lane counter and the capture register.

## Test plan
- Write 0x12345678 to address 0x00 with sel=4'hF:
  - `we` pulses in cycles 1..4 at addr 0x03/0x02/0x01/0x00 with data 0x12/0x34/0x56/0x78.
  - Ack at cycle 5.
- Write sel=4'b0100, data 0x00AB0000, to address 0x08:
  - A single `we` at addr 0x0A with data 0xAB.
  - Ack at cycle 2.
- Read address 0x04 with the model returning lanes 0xAA/0xBB/0xCC/0xDD for lanes 0..3:
  - `we` never asserts.
  - `wb_dat_o`=0xDDCCBBAA with ack at cycle 5.
- Reset asserted in cycle 2 of a full write:
  - Only lanes 3 and 2 are written.
  - `we`=0 from the next edge, there is no ack, and the next request is served normally.
- `wb_cyc_i` dropped in cycle 2 of a full write:
  - All four lanes are still written.
  - `wb_ack_o` stays 0.
- With ERR_EN, a write with sel=0, and separately a read at 0x48:
  - `wb_err_o`=1 at cycle 1, there is no ack, and there is no `we`.
